// File: rtl/frame_slot_scheduler.sv
// frame_slot_scheduler
// Frame tick generator plus a one-grant-per-frame round-robin arbiter that
// shares the screen/update slot among four requesters. Each grant ends on
// done or on a forced release after TIMEOUT cycles.
module frame_slot_scheduler #(
    parameter int unsigned PERIOD  = 10000,
    parameter int unsigned CNT_W   = 19,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TO_W    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] req,
    input  logic       done,
    input  logic       clr_overrun,
    output logic       tick,
    output logic [3:0] grant,
    output logic       busy,
    output logic [1:0] last_id,
    output logic       timeout_err,
    output logic       overrun
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARB     = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    // Round-robin search that starts one position after the last served requester
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        idx   = last;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = idx + 2'd1;
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Binary index to one-hot grant vector
    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    state_t           state_q, state_d;
    logic [1:0]       winner_q, winner_d;
    logic [3:0]       grant_q, grant_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [1:0]       last_id_q, last_id_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;
    logic             overrun_q, overrun_d;
    logic [1:0]       pick_s;

    // Frame counter: runs 0..PERIOD-1 while enabled and flags the wrap as a tick
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = {CNT_W{1'b0}};
                tick_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Slot FSM: next state, winner latch, grant vector, timeout and overrun tracking
    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        grant_d       = grant_q;
        to_cnt_d      = to_cnt_q;
        last_id_d     = last_id_q;
        timeout_err_d = 1'b0;
        pick_s        = rr_pick(req, last_id_q);

        case (state_q)
            S_IDLE: begin
                grant_d = 4'b0000;
                if (tick_q && (req != 4'b0000)) begin
                    state_d = S_ARB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARB: begin
                if (req == 4'b0000) begin
                    state_d = S_IDLE;
                end else begin
                    winner_d = pick_s;
                    grant_d  = onehot(pick_s);
                    to_cnt_d = {TO_W{1'b0}};
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                // done takes precedence over a timeout landing in the same cycle
                if (done) begin
                    grant_d = 4'b0000;
                    state_d = S_RELEASE;
                end else if (to_cnt_q == TO_LAST) begin
                    grant_d       = 4'b0000;
                    timeout_err_d = 1'b1;
                    state_d       = S_RELEASE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_RELEASE: begin
                grant_d   = 4'b0000;
                last_id_d = winner_q;
                to_cnt_d  = {TO_W{1'b0}};
                state_d   = S_IDLE;
            end
            default: begin
                grant_d = 4'b0000;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);

        // A tick that finds the slot occupied is dropped and recorded; set beats clear
        if (tick_q && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State and output registers; reset drops grant without waiting for a clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= {CNT_W{1'b0}};
            tick_q        <= 1'b0;
            state_q       <= S_IDLE;
            winner_q      <= 2'd0;
            grant_q       <= 4'b0000;
            to_cnt_q      <= {TO_W{1'b0}};
            last_id_q     <= 2'd3;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            tick_q        <= tick_d;
            state_q       <= state_d;
            winner_q      <= winner_d;
            grant_q       <= grant_d;
            to_cnt_q      <= to_cnt_d;
            last_id_q     <= last_id_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign tick        = tick_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign last_id     = last_id_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_slot_scheduler.sv
// Bench for frame_slot_scheduler: two instances (TIMEOUT 8 and 20, PERIOD 16)
// share stimulus and are compared every cycle against a behavioural model.
module tb_frame_slot_scheduler;

    localparam int P    = 16;
    localparam int TO_A = 8;
    localparam int TO_B = 20;

    localparam int PH_IDLE = 0;
    localparam int PH_ARB  = 1;
    localparam int PH_HOLD = 2;
    localparam int PH_REL  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic       done;
    logic       clr_overrun;

    logic       tick_a, busy_a, terr_a, ovr_a;
    logic [3:0] grant_a;
    logic [1:0] last_a;
    logic       tick_b, busy_b, terr_b, ovr_b;
    logic [3:0] grant_b;
    logic [1:0] last_b;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model, one slot per instance
    int m_run[2];
    bit m_tick[2];
    int m_phase[2];
    int m_winner[2];
    int m_held[2];
    int m_last[2];
    bit m_terr[2];
    bit m_ovr[2];

    frame_slot_scheduler #(.PERIOD(P), .CNT_W(5), .TIMEOUT(TO_A), .TO_W(4)) u_dut_a (
        .clk(clk), .reset(reset), .enable(enable), .req(req), .done(done),
        .clr_overrun(clr_overrun), .tick(tick_a), .grant(grant_a), .busy(busy_a),
        .last_id(last_a), .timeout_err(terr_a), .overrun(ovr_a)
    );

    frame_slot_scheduler #(.PERIOD(P), .CNT_W(5), .TIMEOUT(TO_B), .TO_W(5)) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable), .req(req), .done(done),
        .clr_overrun(clr_overrun), .tick(tick_b), .grant(grant_b), .busy(busy_b),
        .last_id(last_b), .timeout_err(terr_b), .overrun(ovr_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_run[i]    = 0;
        m_tick[i]   = 1'b0;
        m_phase[i]  = PH_IDLE;
        m_winner[i] = 0;
        m_held[i]   = 0;
        m_last[i]   = 3;
        m_terr[i]   = 1'b0;
        m_ovr[i]    = 1'b0;
    endtask

    // One clock of the reference behaviour, using inputs present at the edge
    task automatic model_step(input int i);
        int lim;
        bit t;
        lim = (i == 0) ? TO_A : TO_B;
        t   = m_tick[i];
        if (!reset) begin
            model_reset(i);
        end else begin
            if (t && m_phase[i] != PH_IDLE) m_ovr[i] = 1'b1;
            else if (clr_overrun)           m_ovr[i] = 1'b0;
            m_terr[i] = 1'b0;
            if (m_phase[i] == PH_IDLE) begin
                if (t && req != 4'b0000) m_phase[i] = PH_ARB;
            end else if (m_phase[i] == PH_ARB) begin
                if (req == 4'b0000) begin
                    m_phase[i] = PH_IDLE;
                end else begin
                    for (int k = 1; k <= 4; k++) begin
                        if (req[(m_last[i] + k) % 4]) begin
                            m_winner[i] = (m_last[i] + k) % 4;
                            break;
                        end
                    end
                    m_held[i]  = 1;
                    m_phase[i] = PH_HOLD;
                end
            end else if (m_phase[i] == PH_HOLD) begin
                if (done) begin
                    m_phase[i] = PH_REL;
                end else if (m_held[i] == lim) begin
                    m_phase[i] = PH_REL;
                    m_terr[i]  = 1'b1;
                end else begin
                    m_held[i]++;
                end
            end else begin
                m_last[i]  = m_winner[i];
                m_phase[i] = PH_IDLE;
            end
            if (enable) begin
                m_run[i]++;
                m_tick[i] = (m_run[i] % P == 0);
            end else begin
                m_run[i]  = 0;
                m_tick[i] = 1'b0;
            end
        end
    endtask

    function automatic logic [3:0] exp_grant(input int i);
        logic [3:0] g;
        g = 4'b0000;
        if (m_phase[i] == PH_HOLD) g[m_winner[i]] = 1'b1;
        return g;
    endfunction

    task automatic compare_all();
        chk("a.tick",    {31'd0, tick_a}, {31'd0, m_tick[0]});
        chk("a.grant",   {28'd0, grant_a}, {28'd0, exp_grant(0)});
        chk("a.busy",    {31'd0, busy_a}, (m_phase[0] != PH_IDLE) ? 32'd1 : 32'd0);
        chk("a.last_id", {30'd0, last_a}, m_last[0]);
        chk("a.tout",    {31'd0, terr_a}, {31'd0, m_terr[0]});
        chk("a.overrun", {31'd0, ovr_a},  {31'd0, m_ovr[0]});
        chk("b.tick",    {31'd0, tick_b}, {31'd0, m_tick[1]});
        chk("b.grant",   {28'd0, grant_b}, {28'd0, exp_grant(1)});
        chk("b.busy",    {31'd0, busy_b}, (m_phase[1] != PH_IDLE) ? 32'd1 : 32'd0);
        chk("b.last_id", {30'd0, last_b}, m_last[1]);
        chk("b.tout",    {31'd0, terr_b}, {31'd0, m_terr[1]});
        chk("b.overrun", {31'd0, ovr_b},  {31'd0, m_ovr[1]});
    endtask

    // Advance one clock: model follows the edge, outputs compared on the falling edge
    task automatic tick_cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_grant_a(input int budget);
        int n;
        n = 0;
        while (grant_a == 4'b0000 && n < budget) begin
            tick_cycle();
            n++;
        end
        chk("wait_grant_timeout", {31'd0, (grant_a == 4'b0000)}, 32'd0);
    endtask

    initial begin
        int cnt;
        int tcnt;
        int n;
        logic [3:0] seen[$];
        logic [3:0] rr_exp[5];

        reset = 1'b0; enable = 1'b1; req = 4'b0000; done = 1'b0; clr_overrun = 1'b0;
        model_reset(0);
        model_reset(1);
        tick_cycle();
        tick_cycle();
        chk("rst.last_id", {30'd0, last_a}, 32'd3);
        chk("rst.grant",   {28'd0, grant_a}, 32'd0);

        // free-running ticks with no requests
        reset = 1'b1;
        cnt = 0;
        for (int c = 0; c < 3 * P; c++) begin
            tick_cycle();
            if (tick_a) cnt++;
        end
        chk("tick_count", cnt, 32'd3);

        // single requester, done three cycles into the grant
        req = 4'b0100;
        wait_grant_a(40);
        tick_cycle();
        tick_cycle();
        done = 1'b1;
        tick_cycle();
        done = 1'b0;
        for (int c = 0; c < 4; c++) tick_cycle();
        chk("single.last_id", {30'd0, last_a}, 32'd2);
        req = 4'b0000;

        // rotation across four persistent requesters, done returned at once
        reset = 1'b0;
        model_reset(0);
        model_reset(1);
        tick_cycle();
        reset = 1'b1;
        req  = 4'b1111;
        done = 1'b1;
        n = 0;
        while (seen.size() < 5 && n < 200) begin
            tick_cycle();
            if (grant_a != 4'b0000) seen.push_back(grant_a);
            n++;
        end
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        chk("rr.count", seen.size(), 32'd5);
        for (int k = 0; k < 5 && k < seen.size(); k++)
            chk($sformatf("rr.grant%0d", k), {28'd0, seen[k]}, {28'd0, rr_exp[k]});
        for (int c = 0; c < 3; c++) tick_cycle();

        // never-finishing requester: forced release after TIMEOUT cycles
        req  = 4'b0001;
        done = 1'b0;
        wait_grant_a(40);
        cnt  = 1;
        tcnt = 0;
        for (int c = 0; c < P - 1; c++) begin
            tick_cycle();
            if (grant_a != 4'b0000) cnt++;
            if (terr_a) tcnt++;
        end
        chk("to.grant_cycles", cnt, TO_A);
        chk("to.pulses", tcnt, 32'd1);
        chk("to.ovr_b_set", {31'd0, ovr_b}, 32'd1);
        chk("to.ovr_a_clear", {31'd0, ovr_a}, 32'd0);
        wait_grant_a(40);
        chk("to.regrant", {28'd0, grant_a}, 32'd1);

        // overrun clear without tick, then clear coincident with a busy tick
        n = 0;
        while ((tick_b || !ovr_b) && n < 100) begin tick_cycle(); n++; end
        clr_overrun = 1'b1;
        tick_cycle();
        clr_overrun = 1'b0;
        chk("ovr.cleared", {31'd0, ovr_b}, 32'd0);
        n = 0;
        while (!(tick_b && busy_b) && n < 100) begin tick_cycle(); n++; end
        chk("ovr.wait_busy_tick", {31'd0, (tick_b && busy_b)}, 32'd1);
        clr_overrun = 1'b1;
        tick_cycle();
        clr_overrun = 1'b0;
        chk("ovr.set_wins", {31'd0, ovr_b}, 32'd1);

        // asynchronous reset in the middle of a grant
        req = 4'b0011;
        wait_grant_a(40);
        #2;
        reset = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        chk("arst.grant_a", {28'd0, grant_a}, 32'd0);
        chk("arst.busy_a",  {31'd0, busy_a}, 32'd0);
        tick_cycle();
        tick_cycle();
        reset = 1'b1;
        wait_grant_a(40);
        chk("arst.first", {28'd0, grant_a}, 32'd1);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            enable      = ($urandom_range(31) != 0);
            req         = 4'($urandom_range(15));
            done        = ($urandom_range(3) == 0);
            clr_overrun = ($urandom_range(15) == 0);
            tick_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
